// File: rtl/adaptive_phase_controller.sv
// adaptive_phase_controller
//   Round-robin traffic phase controller for NUM_DIRS approaches. Green time
//   is a day/night base plus the queued-car count of the approach, saturated.
//   At night, approaches with no queued cars are skipped. A pedestrian walk
//   phase is latched from ped_req. Emergency preemption takes priority.
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   hours_in     hour of day (>=24 treated as night)
//   ped_req      pedestrian button (latched)
//   emg_req      emergency present
//   emg_dir      one-hot emergency approach (lowest set bit wins)
//   lane_counts  per-lane queued-car counts, dir-major
//   green/yellow per-approach light drives (red implied)
//   walk         pedestrian walk
//   phase_dir    approach currently / last served
//   mode         00 all-red, 01 green, 10 yellow, 11 walk/emergency
//   emg_active   emergency green in progress
//   day_night    registered day flag (1 = day)
//   countdown    remaining cycles in current state minus one
//   is_zero      countdown == 0
module adaptive_phase_controller #(
  parameter int NUM_DIRS      = 4,
  parameter int LANES_PER_DIR = 2,
  parameter int COUNT_W       = 8,
  parameter int TIMER_W       = 7,
  parameter int DAY_GREEN     = 20,
  parameter int NIGHT_GREEN   = 8,
  parameter int MAX_GREEN     = 60,
  parameter int YELLOW_TIME   = 3,
  parameter int ALLRED_TIME   = 1,
  parameter int PED_TIME      = 8,
  parameter int EMG_TIME      = 10,
  parameter int DAY_START     = 6,
  parameter int DAY_END       = 18
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [4:0]                                 hours_in,
  input  logic                                       ped_req,
  input  logic                                       emg_req,
  input  logic [NUM_DIRS-1:0]                        emg_dir,
  input  logic [NUM_DIRS*LANES_PER_DIR*COUNT_W-1:0]  lane_counts,
  output logic [NUM_DIRS-1:0]                        green,
  output logic [NUM_DIRS-1:0]                        yellow,
  output logic                                       walk,
  output logic [$clog2(NUM_DIRS)-1:0]                phase_dir,
  output logic [1:0]                                 mode,
  output logic                                       emg_active,
  output logic                                       day_night,
  output logic [TIMER_W-1:0]                         countdown,
  output logic                                       is_zero
);

  localparam int DIR_W = $clog2(NUM_DIRS);
  localparam int SUM_W = COUNT_W + $clog2(LANES_PER_DIR) + 1;
  localparam int GRP_W = LANES_PER_DIR * COUNT_W;

  localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] T_PED    = TIMER_W'(PED_TIME - 1);
  localparam logic [TIMER_W-1:0] T_EMG    = TIMER_W'(EMG_TIME - 1);
  localparam logic [SUM_W-1:0]   B_DAY    = SUM_W'(DAY_GREEN);
  localparam logic [SUM_W-1:0]   B_NIGHT  = SUM_W'(NIGHT_GREEN);
  localparam logic [SUM_W-1:0]   G_SAT    = SUM_W'(MAX_GREEN);

  typedef enum logic [2:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_PED_WALK,
    S_EMG_GREEN
  } state_t;

  state_t               r_state;
  logic [TIMER_W-1:0]   r_cnt;
  logic [DIR_W-1:0]     r_dir;
  logic                 r_ped_pend;
  logic                 r_day;

  logic [SUM_W-1:0]     w_sum [NUM_DIRS];
  logic                 w_emg;
  logic [DIR_W-1:0]     w_emg_idx;
  logic [DIR_W-1:0]     w_next_dir;
  logic                 w_next_ok;
  logic [SUM_W-1:0]     w_len_raw;
  logic [SUM_W-1:0]     w_len;
  logic [TIMER_W-1:0]   w_green_load;
  logic                 w_day_now;
  int                   w_cand;

  function automatic logic [SUM_W-1:0] lane_sum(input logic [GRP_W-1:0] v);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int l = 0; l < LANES_PER_DIR; l++) begin
      s = s + SUM_W'(v[l*COUNT_W +: COUNT_W]);
    end
    return s;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_sum
      assign w_sum[gi] = lane_sum(lane_counts[gi*GRP_W +: GRP_W]);
    end
  endgenerate

  assign w_emg     = emg_req & (|emg_dir);
  assign w_day_now = (hours_in >= 5'(DAY_START)) && (hours_in < 5'(DAY_END)) && (hours_in < 5'd24);

  // Scan from the highest index down so the lowest set bit is the final winner.
  always_comb begin
    w_emg_idx = '0;
    for (int d = NUM_DIRS - 1; d >= 0; d--) begin
      if (emg_dir[d]) w_emg_idx = DIR_W'(d);
    end
  end

  // Rotation candidate: scan offsets from farthest to nearest so the nearest
  // eligible approach after phase_dir wins. At night empty approaches are skipped.
  always_comb begin
    w_next_dir = r_dir;
    w_next_ok  = 1'b0;
    w_cand     = 0;
    for (int k = NUM_DIRS; k >= 1; k--) begin
      w_cand = (int'(r_dir) + k) % NUM_DIRS;
      if (r_day || (w_sum[w_cand] != '0)) begin
        w_next_dir = DIR_W'(w_cand);
        w_next_ok  = 1'b1;
      end
    end
  end

  // Base uses the registered day flag as it stands when the green is loaded.
  assign w_len_raw    = (r_day ? B_DAY : B_NIGHT) + w_sum[w_next_dir];
  assign w_len        = (w_len_raw > G_SAT) ? G_SAT : w_len_raw;
  assign w_green_load = TIMER_W'(w_len - SUM_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_ALL_RED;
      r_cnt      <= T_ALLRED;
      r_dir      <= DIR_W'(NUM_DIRS - 1);
      r_ped_pend <= 1'b0;
      r_day      <= 1'b0;
    end else begin
      r_day <= w_day_now;
      // A press during the walk itself is absorbed by that walk.
      if (ped_req && (r_state != S_PED_WALK)) r_ped_pend <= 1'b1;
      case (r_state)
        S_ALL_RED: begin
          if (r_cnt == '0) begin
            if (w_emg) begin
              r_state <= S_EMG_GREEN;
              r_dir   <= w_emg_idx;
              r_cnt   <= T_EMG;
            end else if (r_ped_pend) begin
              r_state <= S_PED_WALK;
              r_cnt   <= T_PED;
            end else if (w_next_ok) begin
              r_state <= S_GREEN;
              r_dir   <= w_next_dir;
              r_cnt   <= w_green_load;
            end else begin
              r_cnt   <= T_ALLRED;   // nothing queued at night: hold red, retry
            end
          end else begin
            r_cnt <= r_cnt - TIMER_W'(1);
          end
        end
        S_GREEN: begin
          if (w_emg && (w_emg_idx == r_dir)) begin
            r_state <= S_EMG_GREEN;
            r_cnt   <= T_EMG;
          end else if (w_emg || (r_cnt == '0)) begin
            r_state <= S_YELLOW;
            r_cnt   <= T_YELLOW;
          end else begin
            r_cnt <= r_cnt - TIMER_W'(1);
          end
        end
        S_YELLOW: begin
          if (r_cnt == '0) begin
            r_state <= S_ALL_RED;
            r_cnt   <= T_ALLRED;
          end else begin
            r_cnt <= r_cnt - TIMER_W'(1);
          end
        end
        S_PED_WALK: begin
          if (w_emg) begin
            r_state <= S_ALL_RED;        // abort; request stays pending
            r_cnt   <= T_ALLRED;
          end else if (r_cnt == '0) begin
            r_state    <= S_ALL_RED;
            r_cnt      <= T_ALLRED;
            r_ped_pend <= 1'b0;
          end else begin
            r_cnt <= r_cnt - TIMER_W'(1);
          end
        end
        S_EMG_GREEN: begin
          if (w_emg && (w_emg_idx != r_dir)) begin
            r_state <= S_YELLOW;         // emergency moved to another approach
            r_cnt   <= T_YELLOW;
          end else if (r_cnt == '0) begin
            if (w_emg) begin
              r_cnt <= T_EMG;
            end else begin
              r_state <= S_ALL_RED;
              r_cnt   <= T_ALLRED;
            end
          end else begin
            r_cnt <= r_cnt - TIMER_W'(1);
          end
        end
        default: begin
          r_state <= S_ALL_RED;
          r_cnt   <= T_ALLRED;
        end
      endcase
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    mode   = 2'b00;
    if ((r_state == S_GREEN) || (r_state == S_EMG_GREEN)) green[r_dir] = 1'b1;
    if (r_state == S_YELLOW) yellow[r_dir] = 1'b1;
    case (r_state)
      S_GREEN:     mode = 2'b01;
      S_YELLOW:    mode = 2'b10;
      S_PED_WALK:  mode = 2'b11;
      S_EMG_GREEN: mode = 2'b11;
      default:     mode = 2'b00;
    endcase
  end

  assign walk       = (r_state == S_PED_WALK);
  assign emg_active = (r_state == S_EMG_GREEN);
  assign phase_dir  = r_dir;
  assign day_night  = r_day;
  assign countdown  = r_cnt;
  assign is_zero    = (r_cnt == '0);

endmodule

// File: tb/tb_adaptive_phase_controller.sv
// tb_adaptive_phase_controller
//   Directed scenarios followed by randomized traffic, all checked every cycle
//   against a phase-level reference model (phase kind, duration, elapsed).
module tb_adaptive_phase_controller;
  localparam int N = 4;
  localparam int L = 2;
  localparam int CW = 8;
  localparam int TW = 7;
  localparam int DAYG = 20, NIGHTG = 8, MAXG = 60;
  localparam int YEL = 3, ALLR = 1, PEDT = 8, EMGT = 10;

  localparam int K_AR = 0, K_G = 1, K_Y = 2, K_P = 3, K_E = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        hours_in;
  logic              ped_req;
  logic              emg_req;
  logic [N-1:0]      emg_dir;
  logic [N*L*CW-1:0] lane_counts;
  logic [N-1:0]      green, yellow;
  logic              walk;
  logic [1:0]        phase_dir;
  logic [1:0]        mode;
  logic              emg_active, day_night, is_zero;
  logic [TW-1:0]     countdown;

  int checks = 0;
  int failures = 0;

  int m_kind, m_dur, m_el, m_dir;
  bit m_ped, m_day;

  always #5 clk = ~clk;

  adaptive_phase_controller #(
    .NUM_DIRS(N), .LANES_PER_DIR(L), .COUNT_W(CW), .TIMER_W(TW),
    .DAY_GREEN(DAYG), .NIGHT_GREEN(NIGHTG), .MAX_GREEN(MAXG),
    .YELLOW_TIME(YEL), .ALLRED_TIME(ALLR), .PED_TIME(PEDT), .EMG_TIME(EMGT),
    .DAY_START(6), .DAY_END(18)
  ) dut (
    .clk(clk), .rst(rst), .hours_in(hours_in), .ped_req(ped_req),
    .emg_req(emg_req), .emg_dir(emg_dir), .lane_counts(lane_counts),
    .green(green), .yellow(yellow), .walk(walk), .phase_dir(phase_dir),
    .mode(mode), .emg_active(emg_active), .day_night(day_night),
    .countdown(countdown), .is_zero(is_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dsum(input int d);
    int s = 0;
    for (int l = 0; l < L; l++) s += int'(lane_counts[(d*L+l)*CW +: CW]);
    return s;
  endfunction

  task automatic set_lane(input int d, input int l, input int v);
    lane_counts[(d*L+l)*CW +: CW] = CW'(v);
  endtask

  function automatic string kname(input int k);
    case (k)
      K_G: return "GREEN";
      K_Y: return "YELLOW";
      K_P: return "PED_WALK";
      K_E: return "EMG_GREEN";
      default: return "ALL_RED";
    endcase
  endfunction

  task automatic enter(input int k, input int dur);
    m_kind = k; m_dur = dur; m_el = 0;
    $display("[%0t] model %s dir=%0d dur=%0d", $time, kname(k), m_dir, dur);
  endtask

  task automatic model_reset();
    m_dir = N - 1; m_ped = 0; m_day = 0;
    enter(K_AR, ALLR);
  endtask

  // One clock edge of the reference, using the inputs about to be sampled.
  task automatic model_step();
    bit emg, last, ped_old, day_next, found;
    int ed, c, len;
    emg = emg_req && (emg_dir != 0);
    ed = 0;
    for (int d = 0; d < N; d++) if (emg_dir[d]) begin ed = d; break; end
    last = (m_el == m_dur - 1);
    ped_old = m_ped;
    day_next = (hours_in >= 6) && (hours_in < 18);
    if (ped_req && m_kind != K_P) m_ped = 1;
    m_el++;
    case (m_kind)
      K_AR: if (last) begin
        if (emg) begin m_dir = ed; enter(K_E, EMGT); end
        else if (ped_old) enter(K_P, PEDT);
        else begin
          found = 0; c = 0;
          for (int k = 1; k <= N; k++) begin
            c = (m_dir + k) % N;
            if (m_day || dsum(c) > 0) begin found = 1; break; end
          end
          if (found) begin
            len = (m_day ? DAYG : NIGHTG) + dsum(c);
            if (len > MAXG) len = MAXG;
            m_dir = c;
            enter(K_G, len);
          end else enter(K_AR, ALLR);
        end
      end
      K_G: begin
        if (emg && ed == m_dir) enter(K_E, EMGT);
        else if (emg || last) enter(K_Y, YEL);
      end
      K_Y: if (last) enter(K_AR, ALLR);
      K_P: begin
        if (emg) enter(K_AR, ALLR);
        else if (last) begin m_ped = 0; enter(K_AR, ALLR); end
      end
      default: begin
        if (emg && ed != m_dir) enter(K_Y, YEL);
        else if (last) begin
          if (emg) enter(K_E, EMGT);
          else enter(K_AR, ALLR);
        end
      end
    endcase
    m_day = day_next;
  endtask

  task automatic compare_all();
    logic [N-1:0] eg, ey;
    logic [1:0] em;
    eg = '0; ey = '0;
    if (m_kind == K_G || m_kind == K_E) eg[m_dir] = 1'b1;
    if (m_kind == K_Y) ey[m_dir] = 1'b1;
    em = (m_kind == K_G) ? 2'd1 : (m_kind == K_Y) ? 2'd2 : (m_kind == K_AR) ? 2'd0 : 2'd3;
    chk("green", green, eg);
    chk("yellow", yellow, ey);
    chk("walk", walk, m_kind == K_P);
    chk("phase_dir", phase_dir, m_dir);
    chk("mode", mode, em);
    chk("emg_active", emg_active, m_kind == K_E);
    chk("day_night", day_night, m_day);
    chk("countdown", countdown, m_dur - 1 - m_el);
    chk("is_zero", is_zero, m_el == m_dur - 1);
  endtask

  // Called at a falling edge with inputs already set for the next rising edge.
  task automatic tick();
    compare_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_green", green, 0);
    chk("rst_yellow", yellow, 0);
    chk("rst_walk", walk, 0);
    chk("rst_phase_dir", phase_dir, N - 1);
    chk("rst_mode", mode, 0);
    chk("rst_emg", emg_active, 0);
    chk("rst_day", day_night, 0);
    chk("rst_countdown", countdown, ALLR - 1);
    chk("rst_is_zero", is_zero, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [8:0] obs();
    return {green, yellow, walk};
  endfunction

  task automatic wait_obs(input logic [8:0] target, input string tag, input int budget);
    int n = 0;
    while (obs() !== target && n < budget) begin tick(); n++; end
    chk({tag, "_reached"}, obs(), target);
  endtask

  task automatic run_obs(input logic [8:0] target, output int n);
    n = 0;
    while (obs() === target && n < 300) begin tick(); n++; end
  endtask

  function automatic logic [N-1:0] pick_dir();
    int r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return N'($urandom_range(1, 15));
    return N'(1) << $urandom_range(0, N - 1);
  endfunction

  localparam logic [8:0] OFF  = 9'b0000_0000_0;
  localparam logic [8:0] WLK  = 9'b0000_0000_1;
  localparam logic [8:0] G0   = 9'b0001_0000_0;
  localparam logic [8:0] G1   = 9'b0010_0000_0;
  localparam logic [8:0] G2   = 9'b0100_0000_0;
  localparam logic [8:0] G3   = 9'b1000_0000_0;
  localparam logic [8:0] Y0   = 9'b0000_0001_0;
  localparam logic [8:0] Y1   = 9'b0000_0010_0;

  initial begin
    int n, emg_left;
    rst = 1'b0; hours_in = 5'd12; ped_req = 1'b0; emg_req = 1'b0; emg_dir = '0; lane_counts = '0;
    repeat (2) @(negedge clk);

    // Day timing: dir0 5+7, other approaches 1 car.
    set_lane(0, 0, 5); set_lane(0, 1, 7);
    for (int d = 1; d < N; d++) set_lane(d, 0, 1);
    do_reset();
    tick();
    chk("first_green_dir0", obs(), G0);
    wait_obs(G1, "a_g1", 100);
    wait_obs(G0, "a_g0_again", 200);
    run_obs(G0, n);     chk("day_green_len", n, 32);
    run_obs(Y0, n);     chk("yellow_len", n, 3);
    run_obs(OFF, n);    chk("allred_len", n, 1);
    chk("next_green_dir1", obs(), G1);

    // Reset asserted in the middle of a green.
    repeat (3) tick();
    do_reset();
    tick();
    chk("reset_then_g0", obs(), G0);

    // Night: only dir2 has cars.
    hours_in = 5'd22;
    lane_counts = '0; set_lane(2, 0, 3); set_lane(2, 1, 4);
    do_reset();
    tick();
    chk("night_first_dir2", obs(), G2);
    run_obs(G2, n);     chk("night_green_len", n, 15);
    run_obs(9'b0000_0100_0, n); chk("night_yellow_len", n, 3);
    run_obs(OFF, n);    chk("night_allred_len", n, 1);
    chk("night_skip_to_dir2", obs(), G2);

    // Saturation: dir0 255+255 in day mode.
    hours_in = 5'd12; set_lane(0, 0, 255); set_lane(0, 1, 255);
    wait_obs(G0, "sat_g0", 200);
    run_obs(G0, n);     chk("sat_green_len", n, 60);

    // Pedestrian pulse during green[1].
    for (int d = 0; d < N; d++) begin set_lane(d, 0, 1); set_lane(d, 1, 1); end
    wait_obs(G1, "ped_g1", 300);
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    run_obs(G1, n);
    run_obs(Y1, n);     chk("ped_yellow_len", n, 3);
    run_obs(OFF, n);    chk("ped_allred_len", n, 1);
    chk("walk_start", obs(), WLK);
    run_obs(WLK, n);    chk("walk_len", n, 8);
    run_obs(OFF, n);    chk("post_walk_allred", n, 1);
    chk("after_walk_g2", obs(), G2);

    // Emergency for dir3 while green[0].
    wait_obs(G0, "emg_g0", 300);
    emg_req = 1'b1; emg_dir = 4'b1000;
    tick();
    chk("emg_cut_yellow", obs(), Y0);
    run_obs(Y0, n);     chk("emg_yellow_len", n, 3);
    run_obs(OFF, n);    chk("emg_allred_len", n, 1);
    chk("emg_green3", {obs(), emg_active}, {G3, 1'b1});
    repeat (25) tick();
    chk("emg_held", {obs(), emg_active}, {G3, 1'b1});
    emg_req = 1'b0; emg_dir = '0;
    run_obs(G3, n);
    run_obs(OFF, n);    chk("emg_exit_allred", n, 1);
    chk("emg_resume_g0", obs(), G0);

    // Emergency during a walk: walk aborted, then served after the emergency.
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    wait_obs(WLK, "e_walk", 80);
    tick();
    emg_req = 1'b1; emg_dir = 4'b0010;
    tick();
    chk("walk_abort", obs(), OFF);
    run_obs(OFF, n);    chk("abort_allred_len", n, 1);
    chk("emg_dir1", {obs(), emg_active}, {G1, 1'b1});
    repeat (5) tick();
    emg_req = 1'b0; emg_dir = '0;
    run_obs(G1, n);
    run_obs(OFF, n);
    chk("ped_after_emg", obs(), WLK);

    // Randomized traffic.
    emg_left = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if ($urandom_range(0, 199) == 0) hours_in = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 59) == 0) begin
        for (int d = 0; d < N; d++) begin
          if ($urandom_range(0, 1) == 0) begin set_lane(d, 0, 0); set_lane(d, 1, 0); end
          else begin
            set_lane(d, 0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9));
            set_lane(d, 1, $urandom_range(0, 9));
          end
        end
      end
      ped_req = ($urandom_range(0, 39) == 0);
      if (emg_left > 0) begin
        emg_left--;
        if ($urandom_range(0, 29) == 0) emg_dir = pick_dir();
        if (emg_left == 0) emg_req = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        emg_req = 1'b1; emg_dir = pick_dir(); emg_left = $urandom_range(3, 40);
      end
      if ($urandom_range(0, 1999) == 0) do_reset();
      tick();
    end
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
